// File: rtl/datapath_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: opcodes, FS/PS codes,
// control-word layout and FSM states.
package datapath_pkg;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_ABS  = 2'b11;

  // FS = {op[2:0], invB, invA}; invB also supplies carry-in, so SUB is ADD with invB
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_XOR = 5'b01100;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;

  // Field order here is the bit layout of controlWord, MSB (PS) down to SL at bit 0
  typedef struct packed {
    logic [1:0] ps;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       reg_w;
    logic       ram_w;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       sel_b;
    logic       pc_sel;
    logic       sl;
  } ctrl_t;

  function automatic logic [4:0] alu_fs(input logic [10:0] op);
    case (op)
      OP_AND:          return FS_AND;
      OP_ORR:          return FS_OR;
      OP_EOR:          return FS_XOR;
      OP_SUB, OP_SUBS: return FS_SUB;
      default:         return FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the latched instruction (plus status) into the
// EXEC or MEM control word, constant K, and illegal / next-is-MEM flags.
module instr_decode
  import datapath_pkg::*;
#(
  parameter logic [4:0] XZR = 5'd31,
  parameter logic [4:0] LR  = 5'd30
) (
  input  logic [31:0] ir,
  input  logic [4:0]  status,
  input  logic        mem_phase,
  output ctrl_t       cw,
  output logic [63:0] k,
  output logic        illegal,
  output logic        to_mem
);

  logic [4:0]  rd, rn, rm;
  logic [63:0] imm12_zx, imm9_sx, imm19_sx, imm26_sx;
  logic        flag_v, flag_z, flag_n, taken;
  logic        unused_c;

  assign rd       = ir[4:0];
  assign rn       = ir[9:5];
  assign rm       = ir[20:16];
  assign imm12_zx = {52'd0, ir[21:10]};
  assign imm9_sx  = {{55{ir[20]}}, ir[20:12]};
  assign imm19_sx = {{45{ir[23]}}, ir[23:5]};
  assign imm26_sx = {{38{ir[25]}}, ir[25:0]};
  assign flag_v   = status[4];
  assign flag_z   = status[2];
  assign flag_n   = status[1];
  assign unused_c = status[3];

  always_comb begin
    cw      = '0;
    k       = '0;
    illegal = 1'b0;
    to_mem  = 1'b0;
    taken   = 1'b0;
    if (mem_phase) begin
      // second LDUR cycle: address path unchanged, memory data written to Rt
      cw.ps     = PS_INC;
      cw.da     = rd;
      cw.sa     = rn;
      cw.fs     = FS_ADD;
      cw.reg_w  = 1'b1;
      cw.en_mem = 1'b1;
      cw.sel_b  = 1'b1;
      k         = imm9_sx;
    end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
      cw.ps     = PS_INC;
      cw.da     = rd;
      cw.sa     = rn;
      cw.fs     = (ir[31:22] == OP_SUBI) ? FS_SUB : FS_ADD;
      cw.reg_w  = 1'b1;
      cw.en_alu = 1'b1;
      cw.sel_b  = 1'b1;
      k         = imm12_zx;
    end else if (ir[31:26] == OP_B || ir[31:26] == OP_BL) begin
      cw.ps     = PS_REL;
      cw.pc_sel = 1'b1;
      k         = imm26_sx;
      if (ir[31:26] == OP_BL) begin
        cw.da    = LR;
        cw.reg_w = 1'b1;
        cw.en_pc = 1'b1;
      end
    end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
      // Rt | XZR puts Rt on the ALU so live zero reflects Rt == 0
      cw.sa     = rd;
      cw.sb     = XZR;
      cw.fs     = FS_OR;
      cw.pc_sel = 1'b1;
      k         = imm19_sx;
      cw.ps     = (status[0] == (ir[31:24] == OP_CBZ)) ? PS_REL : PS_INC;
    end else if (ir[31:24] == OP_BCOND) begin
      case (ir[3:0])
        COND_EQ: taken = flag_z;
        COND_NE: taken = !flag_z;
        COND_GE: taken = (flag_n == flag_v);
        COND_LT: taken = (flag_n != flag_v);
        default: illegal = 1'b1;
      endcase
      if (!illegal) begin
        cw.pc_sel = 1'b1;
        k         = imm19_sx;
        cw.ps     = taken ? PS_REL : PS_INC;
      end
    end else begin
      case (ir[31:21])
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS: begin
          cw.ps     = PS_INC;
          cw.da     = rd;
          cw.sa     = rn;
          cw.sb     = rm;
          cw.fs     = alu_fs(ir[31:21]);
          cw.reg_w  = 1'b1;
          cw.en_alu = 1'b1;
          cw.sl     = (ir[31:21] == OP_ADDS) || (ir[31:21] == OP_SUBS);
        end
        OP_LDUR: begin
          cw.ps    = PS_HOLD;
          cw.sa    = rn;
          cw.fs    = FS_ADD;
          cw.sel_b = 1'b1;
          k        = imm9_sx;
          to_mem   = 1'b1;
        end
        OP_STUR: begin
          cw.ps    = PS_INC;
          cw.sa    = rn;
          cw.sb    = rd;
          cw.fs    = FS_ADD;
          cw.ram_w = 1'b1;
          cw.sel_b = 1'b1;
          k        = imm9_sx;
        end
        OP_BR: begin
          cw.ps = PS_ABS;
          cw.sa = rn;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// FETCH/EXEC/MEM/HALT sequencer: holds the instruction register and state;
// all datapath controls are combinational from state, IR and status.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter logic [4:0] XZR = 5'd31,
  parameter logic [4:0] LR  = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic [4:0]  status,
  output logic [30:0] controlWord,
  output logic [63:0] K,
  output logic        fetch,
  output logic        halted
);

  state_t      state, state_nx;
  logic [31:0] ir;
  logic        load_ir;
  ctrl_t       dec_cw, cw;
  logic [63:0] dec_k, k_out;
  logic        dec_illegal, dec_to_mem;

  instr_decode #(.XZR(XZR), .LR(LR)) u_decode (
    .ir        (ir),
    .status    (status),
    .mem_phase (state == MEM),
    .cw        (dec_cw),
    .k         (dec_k),
    .illegal   (dec_illegal),
    .to_mem    (dec_to_mem)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (load_ir) ir <= instruction;
    end
  end

  // FETCH and HALT drive an all-zero control word and K
  always_comb begin
    state_nx = state;
    load_ir  = 1'b0;
    cw       = '0;
    k_out    = '0;
    case (state)
      FETCH: begin
        if (instr_valid) begin
          load_ir  = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        cw    = dec_cw;
        k_out = dec_k;
        if (dec_illegal)     state_nx = HALT;
        else if (dec_to_mem) state_nx = MEM;
        else                 state_nx = FETCH;
      end
      MEM: begin
        cw       = dec_cw;
        k_out    = dec_k;
        state_nx = FETCH;
      end
      default: ;
    endcase
  end

  assign controlWord = cw;
  assign K           = k_out;
  assign fetch       = (state == FETCH);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed vector table, hand sequences for
// reset/stall/halt, then random instruction streams against a reference model.
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0;
  logic [4:0]  status = '0;
  logic [30:0] controlWord;
  logic [63:0] K;
  logic        fetch, halted;

  datapath_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .status      (status),
    .controlWord (controlWord),
    .K           (K),
    .fetch       (fetch),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  localparam logic [8:0] F_REGW = 9'h100, F_RAMW = 9'h080, F_MEM = 9'h040, F_ALU = 9'h020;
  localparam logic [8:0] F_PC = 9'h008, F_SELB = 9'h004, F_PCSEL = 9'h002, F_SL = 9'h001;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [4:0]  st;
    logic [30:0] cw;
    logic [63:0] k;
    bit          mem;
    logic [30:0] mcw;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  function automatic logic [30:0] mk_cw(input logic [1:0] ps, input logic [4:0] da, sa, sb, fs,
                                        input logic [8:0] f);
    return {ps, da, sa, sb, fs, f};
  endfunction

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm, input logic [4:0] rt);
    return {op, imm, rt};
  endfunction

  function automatic void add(input string nm, input logic [31:0] ir, input logic [4:0] st,
                              input logic [30:0] cw, input logic [63:0] k, input bit mem,
                              input logic [30:0] mcw);
    vec_t v;
    v.name = nm; v.ir = ir; v.st = st; v.cw = cw; v.k = k; v.mem = mem; v.mcw = mcw;
    tbl.push_back(v);
  endfunction

  // Reference model: names the instruction, then applies its rule. nxt: 0 FETCH, 2 MEM, 3 HALT.
  function automatic void ref_model(input logic [31:0] ir, input logic [4:0] st, input bit mem_ph,
                                    output logic [30:0] cw, output logic [63:0] k, output int nxt);
    logic [1:0] ps; logic [4:0] da, sa, sb, fs; logic [8:0] f;
    logic [63:0] s9, s19, s26;
    string mn;
    bit take, ok;
    ps = 0; da = 0; sa = 0; sb = 0; fs = 0; f = 0; k = 0; nxt = 0; take = 0; ok = 1;
    s9  = {55'd0, ir[20:12]}; if (ir[20]) s9  = s9  - 64'd512;
    s19 = {45'd0, ir[23:5]};  if (ir[23]) s19 = s19 - 64'h80000;
    s26 = {38'd0, ir[25:0]};  if (ir[25]) s26 = s26 - 64'h4000000;
    mn = "ILL";
    if (ir[31:21] == 11'h458) mn = "ADD";
    if (ir[31:21] == 11'h658) mn = "SUB";
    if (ir[31:21] == 11'h450) mn = "AND";
    if (ir[31:21] == 11'h550) mn = "ORR";
    if (ir[31:21] == 11'h650) mn = "EOR";
    if (ir[31:21] == 11'h558) mn = "ADDS";
    if (ir[31:21] == 11'h758) mn = "SUBS";
    if (ir[31:21] == 11'h7C2) mn = "LDUR";
    if (ir[31:21] == 11'h7C0) mn = "STUR";
    if (ir[31:21] == 11'h6B0) mn = "BR";
    if (ir[31:22] == 10'h244) mn = "ADDI";
    if (ir[31:22] == 10'h344) mn = "SUBI";
    if (ir[31:26] == 6'h05)   mn = "B";
    if (ir[31:26] == 6'h25)   mn = "BL";
    if (ir[31:24] == 8'hB4)   mn = "CBZ";
    if (ir[31:24] == 8'hB5)   mn = "CBNZ";
    if (ir[31:24] == 8'h54)   mn = "BCOND";
    case (mn)
      "ADD", "SUB", "AND", "ORR", "EOR", "ADDS", "SUBS": begin
        ps = 1; da = ir[4:0]; sa = ir[9:5]; sb = ir[20:16]; f = F_REGW | F_ALU;
        if (mn == "ADDS" || mn == "SUBS") f = f | F_SL;
        if (mn == "ADD" || mn == "ADDS") fs = 5'b01000;
        if (mn == "SUB" || mn == "SUBS") fs = 5'b01010;
        if (mn == "ORR") fs = 5'b00100;
        if (mn == "EOR") fs = 5'b01100;
      end
      "ADDI", "SUBI": begin
        ps = 1; da = ir[4:0]; sa = ir[9:5]; f = F_REGW | F_ALU | F_SELB;
        fs = (mn == "ADDI") ? 5'b01000 : 5'b01010; k = {52'd0, ir[21:10]};
      end
      "LDUR": begin
        sa = ir[9:5]; fs = 5'b01000; k = s9;
        if (mem_ph) begin ps = 1; da = ir[4:0]; f = F_REGW | F_MEM | F_SELB; end
        else begin f = F_SELB; nxt = 2; end
      end
      "STUR": begin
        ps = 1; sa = ir[9:5]; sb = ir[4:0]; fs = 5'b01000; f = F_RAMW | F_SELB; k = s9;
      end
      "B":  begin ps = 2; f = F_PCSEL; k = s26; end
      "BL": begin ps = 2; da = 5'd30; f = F_PCSEL | F_REGW | F_PC; k = s26; end
      "BR": begin ps = 3; sa = ir[9:5]; end
      "CBZ", "CBNZ": begin
        sa = ir[4:0]; sb = 5'd31; fs = 5'b00100; f = F_PCSEL; k = s19;
        ps = ((st[0] == 1'b1) == (mn == "CBZ")) ? 2'd2 : 2'd1;
      end
      "BCOND": begin
        case (ir[3:0])
          4'h0: take = st[2];
          4'h1: take = !st[2];
          4'hA: take = (st[1] == st[4]);
          4'hB: take = (st[1] != st[4]);
          default: ok = 0;
        endcase
        if (ok) begin ps = take ? 2'd2 : 2'd1; f = F_PCSEL; k = s19; end
        else nxt = 3;
      end
      default: nxt = 3;
    endcase
    cw = {ps, da, sa, sb, fs, f};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0] a, b, c; logic [10:0] rop; logic [3:0] cd; logic [31:0] r;
    a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
    case ($urandom_range(0, 6))
      0: rop = 11'h458; 1: rop = 11'h658; 2: rop = 11'h450; 3: rop = 11'h550;
      4: rop = 11'h650; 5: rop = 11'h558; default: rop = 11'h758;
    endcase
    case ($urandom_range(0, 4))
      0: cd = 4'h0; 1: cd = 4'h1; 2: cd = 4'hA; 3: cd = 4'hB; default: cd = 4'($urandom);
    endcase
    case ($urandom_range(0, 15))
      0, 1, 2: r = enc_r(rop, a, b, c);
      3:       r = enc_i(($urandom_range(0, 1) == 1) ? 10'h244 : 10'h344, 12'($urandom), b, c);
      4, 5:    r = enc_d(11'h7C2, 9'($urandom), b, c);
      6:       r = enc_d(11'h7C0, 9'($urandom), b, c);
      7:       r = enc_b(6'h05, 26'($urandom));
      8:       r = enc_b(6'h25, 26'($urandom));
      9:       r = enc_r(11'h6B0, a, b, c);
      10:      r = enc_cb(8'hB4, 19'($urandom), c);
      11:      r = enc_cb(8'hB5, 19'($urandom), c);
      12, 13:  r = enc_cb(8'h54, 19'($urandom), {1'b0, cd});
      14:      r = $urandom;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Called one step after a rising edge; returns aligned the same way.
  task automatic do_reset();
    instr_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("reset cw", 64'(controlWord), 64'd0);
    check("reset K", K, 64'd0);
    check("reset fetch", 64'(fetch), 64'd1);
    check("reset halted", 64'(halted), 64'd0);
    reset = 1'b1;
    #1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    instruction = v.ir; status = v.st; instr_valid = 1'b1;
    settle();
    check({v.name, " fetch"}, 64'(fetch), 64'd1);
    check({v.name, " fetch cw"}, 64'(controlWord), 64'd0);
    tick();
    instr_valid = 1'b0; instruction = $urandom;
    settle();
    check({v.name, " exec cw"}, 64'(controlWord), 64'(v.cw));
    check({v.name, " exec K"}, K, v.k);
    check({v.name, " exec fetch"}, 64'(fetch), 64'd0);
    if (v.mem) begin
      tick(); settle();
      check({v.name, " mem cw"}, 64'(controlWord), 64'(v.mcw));
      check({v.name, " mem K"}, K, v.k);
    end
    tick(); settle();
    check({v.name, " back to fetch"}, 64'(fetch), 64'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [30:0] ecw; logic [63:0] ek; int nxt, ph, hcnt; bit ef, eh;
    logic [31:0] mir;

    add("ADDI", enc_i(10'h244, 12'd5, 5'd2, 5'd1), 5'd0,
        mk_cw(2'd1, 5'd1, 5'd2, 5'd0, 5'b01000, F_REGW | F_ALU | F_SELB), 64'd5, 0, '0);
    add("LDUR", enc_d(11'h7C2, 9'h1F8, 5'd4, 5'd3), 5'd0,
        mk_cw(2'd0, 5'd0, 5'd4, 5'd0, 5'b01000, F_SELB), 64'hFFFF_FFFF_FFFF_FFF8, 1,
        mk_cw(2'd1, 5'd3, 5'd4, 5'd0, 5'b01000, F_REGW | F_MEM | F_SELB));
    add("CBZ taken", enc_cb(8'hB4, 19'h7FFFE, 5'd5), 5'b00001,
        mk_cw(2'd2, 5'd0, 5'd5, 5'd31, 5'b00100, F_PCSEL), 64'hFFFF_FFFF_FFFF_FFFE, 0, '0);
    add("CBZ not", enc_cb(8'hB4, 19'h7FFFE, 5'd5), 5'b00000,
        mk_cw(2'd1, 5'd0, 5'd5, 5'd31, 5'b00100, F_PCSEL), 64'hFFFF_FFFF_FFFF_FFFE, 0, '0);
    add("SUBS", enc_r(11'h758, 5'd3, 5'd2, 5'd1), 5'b00010,
        mk_cw(2'd1, 5'd1, 5'd2, 5'd3, 5'b01010, F_REGW | F_ALU | F_SL), 64'd0, 0, '0);
    add("B.LT", enc_cb(8'h54, 19'd4, 5'h0B), 5'b00010,
        mk_cw(2'd2, 5'd0, 5'd0, 5'd0, 5'd0, F_PCSEL), 64'd4, 0, '0);
    add("B.GE", enc_cb(8'h54, 19'd4, 5'h0A), 5'b00010,
        mk_cw(2'd1, 5'd0, 5'd0, 5'd0, 5'd0, F_PCSEL), 64'd4, 0, '0);
    add("BL", enc_b(6'h25, 26'd16), 5'd0,
        mk_cw(2'd2, 5'd30, 5'd0, 5'd0, 5'd0, F_REGW | F_PC | F_PCSEL), 64'd16, 0, '0);
    add("STUR", enc_d(11'h7C0, 9'd3, 5'd8, 5'd7), 5'd0,
        mk_cw(2'd1, 5'd0, 5'd8, 5'd7, 5'b01000, F_RAMW | F_SELB), 64'd3, 0, '0);
    add("BR", enc_r(11'h6B0, 5'd0, 5'd9, 5'd0), 5'd0,
        mk_cw(2'd3, 5'd0, 5'd9, 5'd0, 5'd0, 9'd0), 64'd0, 0, '0);
    add("CBNZ", enc_cb(8'hB5, 19'd8, 5'd2), 5'd0,
        mk_cw(2'd2, 5'd0, 5'd2, 5'd31, 5'b00100, F_PCSEL), 64'd8, 0, '0);
    add("EOR", enc_r(11'h650, 5'd6, 5'd5, 5'd4), 5'd0,
        mk_cw(2'd1, 5'd4, 5'd5, 5'd6, 5'b01100, F_REGW | F_ALU), 64'd0, 0, '0);

    // reset state, then release between edges
    #7;
    check("por cw", 64'(controlWord), 64'd0);
    check("por K", K, 64'd0);
    check("por fetch", 64'(fetch), 64'd1);
    check("por halted", 64'(halted), 64'd0);
    #5 reset = 1'b1;
    tick();

    // FETCH stalls while instr_valid is low
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b0; instruction = $urandom;
      settle();
      check("stall fetch", 64'(fetch), 64'd1);
      check("stall cw", 64'(controlWord), 64'd0);
      tick();
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset asserted in the middle of an ADD's EXEC cycle
    instruction = enc_r(11'h458, 5'd3, 5'd2, 5'd1); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    settle();
    check("ADD exec cw", 64'(controlWord), 64'(mk_cw(2'd1, 5'd1, 5'd2, 5'd3, 5'b01000, F_REGW | F_ALU)));
    reset = 1'b0; #1;
    check("abort cw", 64'(controlWord), 64'd0);
    check("abort fetch", 64'(fetch), 64'd1);
    tick(); settle();
    check("held reset cw", 64'(controlWord), 64'd0);
    reset = 1'b1;
    tick(); settle();
    check("post reset fetch", 64'(fetch), 64'd1);
    check("post reset cw", 64'(controlWord), 64'd0);
    tick();

    // 32'h0 is illegal: HALT is sticky even with valid instructions offered
    instruction = 32'h0; instr_valid = 1'b1;
    tick();
    settle();
    check("zero exec cw", 64'(controlWord), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      instruction = enc_r(11'h458, 5'd1, 5'd1, 5'd1);
      settle();
      check("halt halted", 64'(halted), 64'd1);
      check("halt cw", 64'(controlWord), 64'd0);
      check("halt K", K, 64'd0);
      check("halt fetch", 64'(fetch), 64'd0);
      tick();
    end
    do_reset();

    // unsupported branch condition also halts
    instruction = enc_cb(8'h54, 19'd4, 5'h0C); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    settle();
    check("bad cond cw", 64'(controlWord), 64'd0);
    tick(); settle();
    check("bad cond halted", 64'(halted), 64'd1);
    tick();
    do_reset();

    // random instruction stream against the reference model
    ph = 0; hcnt = 0; mir = '0; nxt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0 || hcnt >= 3) begin
        do_reset();
        ph = 0; hcnt = 0;
      end
      instruction = gen_instr();
      instr_valid = ($urandom_range(0, 3) != 0);
      status      = 5'($urandom);
      settle();
      ecw = '0; ek = '0; ef = 0; eh = 0;
      case (ph)
        0: ef = 1;
        1: ref_model(mir, status, 0, ecw, ek, nxt);
        2: ref_model(mir, status, 1, ecw, ek, nxt);
        default: eh = 1;
      endcase
      check("rnd cw", 64'(controlWord), 64'(ecw));
      check("rnd K", K, ek);
      check("rnd fetch", 64'(fetch), 64'(ef));
      check("rnd halted", 64'(halted), 64'(eh));
      if (controlWord[8]) check("rnd en onehot", 64'($countones(controlWord[6:3])), 64'd1);
      else                check("rnd en idle", 64'(controlWord[6:3]), 64'd0);
      case (ph)
        0: if (instr_valid) begin mir = instruction; ph = 1; end
        1: ph = (nxt == 3) ? 3 : (nxt == 2) ? 2 : 0;
        2: ph = 0;
        default: hcnt++;
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
